serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
//  Bit-serial multi-bit adder sequencer. Feeds a single 1-bit full-adder cell one operand bit per cycle, LSB first.
//  Registers the carry between bits and assembles the WIDTH-bit sum in a shift register.
//  Sits directly upstream of the fa cell and drives its a/b/cin inputs every cycle.
//  Exposes a valid/ready request/result handshake to the surrounding datapath.
// PARAMETERS
//  WIDTH     8   operand/sum width in bits; legal range 1..32
//  CNT_W     $clog2(WIDTH+1)   bit-counter width; derived, not overridden
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      reset, synchronous, active-low
//  req_valid    in   1      operands a/b/cin valid
//  req_ready    out  1      sequencer can accept; high only in IDLE
//  a            in   WIDTH  operand A, sampled on accept
//  b            in   WIDTH  operand B, sampled on accept
//  cin          in   1      carry-in to bit 0, sampled on accept
//  res_valid    out  1      sum/cout valid; held until taken
//  res_ready    in   1      consumer takes result
//  sum          out  WIDTH  result bits
//  cout         out  1      carry out of MSB
//  busy         out  1      high in RUN
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
//  - Reset (rst_n=0 at posedge): state=IDLE, req_ready=0 during the reset cycle, then 1.
//    res_valid=0, busy=0, sum=0, cout=0, carry reg=0, counter=0.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: req_ready=1. req_valid&req_ready at posedge does the following:
//    a, b load into shift regs; carry reg <= cin; counter <= 0; go to RUN.
//  - RUN: each cycle the fa cell sees a_sh[0], b_sh[0], carry.
//    At posedge: fa.sum shifts into the sum MSB (sum shifts right), carry <= fa.cout, a_sh/b_sh shift right, counter++.
//    After exactly WIDTH RUN cycles (counter==WIDTH-1 at that edge): go to DONE and set cout <= fa.cout.
//  - DONE: res_valid=1, sum/cout stable. On res_valid&res_ready go to IDLE, res_valid=0 next cycle.
//  - Latency: accept edge + WIDTH cycles to res_valid=1. Min req-to-req spacing is WIDTH+2 cycles.
//  - req_valid outside IDLE is ignored; a, b and cin may change freely after accept.
//  - res_ready before DONE has no effect. A result is never dropped and never duplicated.
//  - No accept occurs in the same cycle as the DONE->IDLE hand-off.
//  - WIDTH=1: a single RUN cycle; no wrap-around, so the counter never exceeds WIDTH-1.
//  - Arithmetic: {cout,sum} == a + b + cin, unsigned, exact modulo 2^(WIDTH+1).
//  - rst_n low in RUN or DONE aborts the operation. All outputs take reset values on the next edge; no partial result is presented.
// CONFIGURATION
//  SERIAL_ADD_OVF_EN defined:
//    - Adds output port ovf (1 bit, reset 0).
//    - In the final RUN cycle, ovf <= carry_into_MSB ^ fa.cout (two's-complement signed overflow).
//    - ovf is valid with res_valid and held through DONE.
//  SERIAL_ADD_OVF_EN undefined:
//    - No ovf port and no extra registers.
//    - All other behaviour is identical.
// STRUCTURE
//  - Shared package serial_add_pkg holds:
//    - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} sa_state_t;
//    - localparam SA_MAX_WIDTH = 32.
//  - One sub-module: fa (existing 1-bit full-adder cell), instantiated once as u_fa.
//  - Shift regs, carry flop, counter and FSM live in this module.
// TESTING
//  - Reset: hold rst_n=0 for 2 clk -> req_ready=0, res_valid=0, sum=0, cout=0. First cycle after release -> req_ready=1.
//  - WIDTH=8, a=0x35, b=0x4A, cin=0: accept -> res_valid rises 8 cycles later with sum=0x7F, cout=0.
//  - WIDTH=8, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1. With SERIAL_ADD_OVF_EN, a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1.
//  - Backpressure: hold res_ready=0 for 5 cycles in DONE and pulse req_valid -> result stable, req_ready=0, no new accept.
//    Then res_ready=1 -> IDLE next cycle.
//  - Abort: drop rst_n for 1 cycle at the 4th RUN cycle -> all outputs reset, no res_valid. A new request then completes correctly.
//  - Random: 1000 requests, WIDTH in {1,8,32}, random res_ready -> every result matches a+b+cin, in order, exactly once.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} sa_state_t;

  localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_add_seq_fa.sv
// 1-bit full-adder cell driven one operand bit per cycle by serial_add_seq.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one fa cell, LSB first, valid/ready request and result.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_cout;
  logic last_bit;
  logic accept;
  logic take;

  fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign take     = (state_q == ST_DONE) && res_ready;

  // Masked during the reset cycle so nothing upstream sees a handshake that reset will discard.
  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Each result bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
        sum_d             = sum_q >> 1;
        sum_d[WIDTH-1]    = fa_sum;
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        carry_d           = fa_cout;
        if (last_bit) begin
          cout_d  = fa_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (take) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq at WIDTH 8, 1 and 32 (instances 0, 1, 2).
module tb_serial_add_seq;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req_valid_s, req_ready_s, res_valid_s, res_ready_s;
  logic [2:0]       cin_s, cout_s, busy_s, ovf_s;
  logic [2:0][31:0] a_s, b_s, sum_s;
  bit               rr_rand;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [3][$];

  always #5 clk = ~clk;

  function automatic int width_of(input int i);
    case (i)
      0:       return 8;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv);
    exp_t        e;
    logic [31:0] mask;
    logic [32:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full   = {1'b0, av & mask} + {1'b0, bv & mask} + {32'h0, cv};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
`ifdef SERIAL_ADD_OVF_EN
    e.ovf  = (av[w-1] == bv[w-1]) && (e.sum[w-1] != av[w-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
    logic [W-1:0] sum_w;

    serial_add_seq #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid_s[g]),
      .req_ready (req_ready_s[g]),
      .a         (a_s[g][W-1:0]),
      .b         (b_s[g][W-1:0]),
      .cin       (cin_s[g]),
      .res_valid (res_valid_s[g]),
      .res_ready (res_ready_s[g]),
      .sum       (sum_w),
      .cout      (cout_s[g]),
      .busy      (busy_s[g])
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf_s[g])
`endif
    );

    assign sum_s[g] = 32'(sum_w);
`ifndef SERIAL_ADD_OVF_EN
    assign ovf_s[g] = 1'b0;
`endif

    // Monitor: a result is taken on the next posedge whenever valid and ready are both high here.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && res_valid_s[g] === 1'b1 && res_ready_s[g] === 1'b1) begin
        if (sb[g].size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb[g].pop_front();
          check("result", {29'd0, ovf_s[g], cout_s[g], sum_s[g]},
                {29'd0, e.ovf, e.cout, e.sum});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) res_ready_s = 3'($urandom);
    end
  end

  // Presents a request and returns just after the accepting edge, expectation queued.
  task automatic send(input int i, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, output bit ok);
    ok = 1'b0;
    @(posedge clk);
    #1;
    a_s[i] = av; b_s[i] = bv; cin_s[i] = cv; req_valid_s[i] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready_s[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid_s[i] = 1'b0;
      return;
    end
    @(posedge clk);
    sb[i].push_back(model(width_of(i), av, bv, cv));
    #1;
    req_valid_s[i] = 1'b0;
    a_s[i] = $urandom; b_s[i] = $urandom; cin_s[i] = 1'($urandom);
  endtask

  task automatic wait_valid(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (res_valid_s[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic release0();
    @(posedge clk); #1; res_ready_s[0] = 1'b1;
    @(posedge clk); #1; res_ready_s[0] = 1'b0;
    @(negedge clk);
    check("handoff", {62'd0, res_valid_s[0], req_ready_s[0]}, 64'b01);
  endtask

  task automatic directed(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input logic [31:0] es, input logic ec);
    bit ok;
    send(0, av, bv, cv, ok);
    if (!ok) return;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("lat_before", {62'd0, busy_s[0], res_valid_s[0]}, 64'b10);
    @(negedge clk);
    check("lat_valid", {63'd0, res_valid_s[0]}, 64'd1);
    check("dir_sum", {32'd0, sum_s[0]}, {32'd0, es});
    check("dir_cout", {63'd0, cout_s[0]}, {63'd0, ec});
    release0();
  endtask

  task automatic rand_run(input int i, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(i, $urandom, $urandom, 1'($urandom), ok);
    end
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; rr_rand = 1'b0;
    req_valid_s = '0; res_ready_s = '0; cin_s = '0; a_s = '0; b_s = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {61'd0, req_ready_s}, 64'd0);
    check("rst_res_valid", {61'd0, res_valid_s}, 64'd0);
    check("rst_cout_busy", {58'd0, cout_s, busy_s}, 64'd0);
    for (int i = 0; i < 3; i++) check("rst_sum", {32'd0, sum_s[i]}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {61'd0, req_ready_s}, 64'b111);

    directed(32'h35, 32'h4A, 1'b0, 32'h7F, 1'b0);
    directed(32'hFF, 32'h01, 1'b1, 32'h01, 1'b1);

`ifdef SERIAL_ADD_OVF_EN
    send(0, 32'h7F, 32'h01, 1'b0, ok);
    wait_valid(0, ok);
    check("ovf_sum", {32'd0, sum_s[0]}, 64'h80);
    check("ovf_flag", {63'd0, ovf_s[0]}, 64'd1);
    release0();
`endif

    // Backpressure: result held, a request pulse in DONE must not be accepted.
    send(0, 32'h12, 32'h34, 1'b0, ok);
    wait_valid(0, ok);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_valid_s[0] = (c == 1 || c == 2);
      a_s[0] = $urandom; b_s[0] = $urandom;
      @(negedge clk);
      check("bp_hold", {61'd0, res_valid_s[0], req_ready_s[0], busy_s[0]}, 64'b100);
      check("bp_sum", {31'd0, cout_s[0], sum_s[0]}, 64'h46);
    end
    release0();
    @(negedge clk);
    check("bp_no_accept", {63'd0, busy_s[0]}, 64'd0);

    // Abort in the 4th RUN cycle.
    send(0, 32'hA5, 32'h5A, 1'b1, ok);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    sb[0].delete();
    @(negedge clk);
    check("abort_state", {60'd0, res_valid_s[0], busy_s[0], cout_s[0], req_ready_s[0]},
          64'b0001);
    check("abort_sum", {32'd0, sum_s[0]}, 64'd0);
    ok = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid_s[0]) ok = 1'b1;
    end
    check("abort_no_valid", {63'd0, ok}, 64'd0);
    directed(32'h0F, 32'hF0, 1'b1, 32'h00, 1'b1);

    // Random traffic on all three widths at once, random consumer backpressure.
    rr_rand = 1'b1;
    fork
      rand_run(0, 334);
      rand_run(1, 333);
      rand_run(2, 333);
    join
    for (int n = 0; n < 2000; n++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
      @(posedge clk);
    end
    rr_rand = 1'b0;
    for (int i = 0; i < 3; i++) check("sb_drained", 64'(sb[i].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
